// File: rtl/codec_cfg_pkg.sv
// Shared types and constants for the codec power-up sequencer: FSM encodings,
// codec register addresses, table entry layout and the word-length encoder.
package codec_cfg_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PWRUP = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_ERROR = 3'd6;

    localparam logic [6:0] R0  = 7'd0;
    localparam logic [6:0] R1  = 7'd1;
    localparam logic [6:0] R2  = 7'd2;
    localparam logic [6:0] R3  = 7'd3;
    localparam logic [6:0] R4  = 7'd4;
    localparam logic [6:0] R6  = 7'd6;
    localparam logic [6:0] R10 = 7'd10;
    localparam logic [6:0] R14 = 7'd14;
    localparam logic [6:0] R49 = 7'd49;
    localparam logic [6:0] R50 = 7'd50;
    localparam logic [6:0] R51 = 7'd51;
    localparam logic [6:0] R52 = 7'd52;
    localparam logic [6:0] R53 = 7'd53;
    localparam logic [6:0] R54 = 7'd54;
    localparam logic [6:0] R55 = 7'd55;

    // Packed so that the entry maps directly onto the 16-bit frame, address first.
    typedef struct packed {
        logic [6:0] addr;
        logic [8:0] data;
    } entry_t;

    function automatic logic [1:0] wl_code(input int wl);
        case (wl)
            16:      return 2'b00;
            20:      return 2'b01;
            32:      return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

endpackage

// File: rtl/codec_cfg_sequencer_if.sv
// Handshake between the configuration sequencer and the I2C byte-write master.
interface codec_cfg_sequencer_if;
    logic        i2c_req;
    logic [6:0]  i2c_dev_addr;
    logic [15:0] i2c_wdata;
    logic        i2c_ack;
    logic        i2c_nack;

    modport master (output i2c_req, i2c_dev_addr, i2c_wdata, input i2c_ack, i2c_nack);
    modport slave  (input i2c_req, i2c_dev_addr, i2c_wdata, output i2c_ack, i2c_nack);
endinterface

// File: rtl/codec_cfg_rom.sv
// Fixed power-up register table for the codec; entry 0 is always the software reset.
module codec_cfg_rom
    import codec_cfg_pkg::*;
#(
    parameter int WL = 24
) (
    input  logic [4:0] idx,
    output entry_t     entry
);

    always_comb begin
        entry = '{R49, 9'h002};
        case (idx)
            5'd0:  entry = '{R0,  9'h000};
            5'd1:  entry = '{R1,  9'h00B};
            5'd2:  entry = '{R2,  9'h180};
            // Interface control: I2S format, word length from WL.
            5'd3:  entry = '{R4,  {2'b00, wl_code(WL), 2'b10, 3'b000}};
            5'd4:  entry = '{R3,  9'h06F};
            5'd5:  entry = '{R6,  9'h000};
            5'd6:  entry = '{R10, 9'h008};
            5'd7:  entry = '{R14, 9'h108};
            5'd8:  entry = '{R49, 9'h002};
            5'd9:  entry = '{R50, 9'h001};
            5'd10: entry = '{R51, 9'h001};
            5'd11: entry = '{R52, 9'h139};
            5'd12: entry = '{R53, 9'h139};
            5'd13: entry = '{R54, 9'h039};
            5'd14: entry = '{R55, 9'h139};
            5'd15: entry = '{R3,  9'h06F};
            default: entry = '{R49, 9'h002};
        endcase
    end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// Power-up configuration sequencer: walks the register table over the I2C handshake.
// Optional headphone-volume writes in DONE when CODEC_CFG_VOLUME_EN is defined.
module codec_cfg_sequencer
    import codec_cfg_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR     = 7'h1A,
    parameter int         WL           = 24,
    parameter int         NUM_REGS     = 16,
    parameter int         MAX_RETRY    = 3,
    parameter int         PWRUP_CYCLES = 500000,
    parameter int         GAP_CYCLES   = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    codec_cfg_sequencer_if.master bus,
`ifdef CODEC_CFG_VOLUME_EN
    input  logic                  vol_req,
    input  logic [5:0]            vol_val,
    output logic                  vol_ack,
`endif
    output logic                  cfg_busy,
    output logic                  cfg_done,
    output logic                  cfg_err,
    output logic [4:0]            cur_idx
);

    localparam int CNT_MAX = (PWRUP_CYCLES > GAP_CYCLES) ? PWRUP_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [2:0]       state;
    logic [4:0]       idx;
    logic [2:0]       retry;
    logic [CNT_W-1:0] cnt;
    logic             req;
    logic [15:0]      wdata;
    entry_t           rom_entry;
    entry_t           nxt_entry;

`ifdef CODEC_CFG_VOLUME_EN
    logic             vol_mode;
    logic             vol_sel;
    logic [5:0]       vol_lat;
`endif

    codec_cfg_rom #(.WL(WL)) u_rom (.idx(idx), .entry(rom_entry));

    always_comb begin
        nxt_entry = rom_entry;
`ifdef CODEC_CFG_VOLUME_EN
        // HP L then HP R, both with the update bit set.
        if (vol_mode)
            nxt_entry = '{(vol_sel ? R53 : R52), {3'b100, vol_lat}};
`endif
    end

    assign bus.i2c_req      = req;
    assign bus.i2c_wdata    = wdata;
    assign bus.i2c_dev_addr = DEV_ADDR;
    assign cur_idx          = idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            retry    <= '0;
            cnt      <= '0;
            req      <= 1'b0;
            wdata    <= '0;
            cfg_busy <= 1'b0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
`ifdef CODEC_CFG_VOLUME_EN
            vol_mode <= 1'b0;
            vol_sel  <= 1'b0;
            vol_lat  <= '0;
            vol_ack  <= 1'b0;
`endif
        end else begin
`ifdef CODEC_CFG_VOLUME_EN
            vol_ack <= 1'b0;
`endif
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        cfg_done <= 1'b0;
                        cfg_err  <= 1'b0;
                        cfg_busy <= 1'b1;
                        idx      <= '0;
                        retry    <= '0;
                        cnt      <= '0;
                        state    <= ST_PWRUP;
                    end
`ifdef CODEC_CFG_VOLUME_EN
                    else if (state == ST_DONE && vol_req) begin
                        vol_mode <= 1'b1;
                        vol_sel  <= 1'b0;
                        vol_lat  <= vol_val;
                        retry    <= '0;
                        cfg_busy <= 1'b1;
                        state    <= ST_ISSUE;
                    end
`endif
                end
                ST_PWRUP: begin
                    if (cnt == CNT_W'(PWRUP_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= ST_ISSUE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_ISSUE: begin
                    req   <= 1'b1;
                    wdata <= nxt_entry;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // nack wins over a simultaneous ack
                    if (bus.i2c_nack) begin
                        req <= 1'b0;
                        if (retry < 3'(MAX_RETRY)) begin
                            retry <= retry + 3'd1;
                            state <= ST_GAP;
                        end else begin
                            cfg_err  <= 1'b1;
                            cfg_busy <= 1'b0;
                            state    <= ST_ERROR;
`ifdef CODEC_CFG_VOLUME_EN
                            vol_mode <= 1'b0;
`endif
                        end
                    end else if (bus.i2c_ack) begin
                        req   <= 1'b0;
                        retry <= '0;
`ifdef CODEC_CFG_VOLUME_EN
                        if (vol_mode) begin
                            if (!vol_sel) begin
                                vol_sel <= 1'b1;
                                state   <= ST_GAP;
                            end else begin
                                vol_mode <= 1'b0;
                                vol_ack  <= 1'b1;
                                cfg_busy <= 1'b0;
                                state    <= ST_DONE;
                            end
                        end else
`endif
                        if (idx == 5'(NUM_REGS - 1)) begin
                            cfg_done <= 1'b1;
                            cfg_busy <= 1'b0;
                            state    <= ST_DONE;
                        end else begin
                            idx   <= idx + 5'd1;
                            state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= ST_ISSUE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
